branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Execute-stage branch resolution controller for the in-order RV32I pipeline. Fetch uses static not-taken prediction.
- Drives the branch_unit comparator and computes the branch/jump target.
- On a taken branch or jump, issues a PC redirect to fetch with a valid/ready handshake and flushes younger instructions.
- Raises an instruction-address-misaligned trap instead of redirecting when the target is not word aligned.
- Keeps resolved-branch and taken-branch performance counters.

Parameters:
- DATA_WIDTH, 32, width of operands, PC and target.
- CNT_WIDTH, 32, width of each performance counter; counters wrap modulo 2^CNT_WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_ex_valid  input  1  EX holds a valid instruction this cycle.
- i_branch  input  1  instruction is a branch or jump.
- i_branch_op  input  3  BRANCH_* opcode (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL_JALR).
- i_jalr  input  1  target base is rs1 (JALR), else PC.
- i_rs1  input  DATA_WIDTH  rs1 operand.
- i_rs2  input  DATA_WIDTH  rs2 operand.
- i_pc  input  DATA_WIDTH  PC of the EX instruction.
- i_imm  input  DATA_WIDTH  sign-extended immediate.
- i_redirect_ready  input  1  fetch accepts the redirect.
- o_redirect_valid  output  1  redirect pending.
- o_redirect_pc  output  DATA_WIDTH  redirect target.
- o_flush  output  1  kill IF/ID and ID/EX contents.
- o_ex_stall  output  1  hold EX and upstream stages.
- o_trap  output  1  misaligned-target trap, 1-cycle pulse.
- o_trap_tval  output  DATA_WIDTH  faulting target address.
- o_br_count  output  CNT_WIDTH  resolved branches/jumps.
- o_taken_count  output  CNT_WIDTH  redirects issued.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including o_redirect_pc, o_trap_tval and both counters.
- Reset asserted mid-redirect or mid-trap drops the pending redirect immediately (asynchronous clear).
- Comparator: the branch_unit instance sees i_branch & i_ex_valid, i_branch_op, i_a=i_rs1, i_b=i_rs2, and produces take.
- Target calculation:
  - i_jalr=1: (i_rs1+i_imm) & ~1.
  - i_jalr=0: i_pc+i_imm.
  - Addition truncates to DATA_WIDTH; overflow is ignored.
- A resolution event occurs when state=IDLE, i_ex_valid=1 and i_branch=1. On each event o_br_count increments.
- State machine:
  - IDLE, event with take=0: no action.
  - IDLE, event with take=1 and target[1:0]==0: state→REDIRECT, o_redirect_pc←target, o_taken_count increments.
  - IDLE, event with take=1 and target[1:0]!=0: state→TRAP, o_trap_tval←target. The taken counter does not increment.
  - REDIRECT: o_redirect_valid=o_flush=o_ex_stall=1. o_redirect_pc is held stable. If i_redirect_ready=1 → IDLE next cycle; otherwise remain.
  - TRAP: o_trap=o_flush=1 for exactly one cycle → IDLE.
- Latency: the event occurs in cycle N; redirect/trap outputs assert in cycle N+1. All outputs are registered or decoded from state only.
- The minimum redirect lasts 1 cycle (ready already high at N+1).
- i_ex_valid and i_branch are ignored outside IDLE; no events are counted there.
- o_redirect_valid never drops before the handshake completes.
- Both counters may increment in the same cycle. At all-ones a counter wraps to 0.
- i_branch=0 with i_ex_valid=1 has no effect. The take output is gated by i_branch inside branch_unit.

Decomposition:
- Shared defines header: DATA_WIDTH and the BRANCH_* opcode encodings, already used by branch_unit.
- Add the controller state encodings there: IDLE=2'd0, REDIRECT=2'd1, TRAP=2'd2.
- Sub-module: branch_unit, instantiated unchanged as the comparator. The target adder, FSM and counters stay in branch_redirect_ctrl.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, ready=1 → next cycle o_redirect_valid=1, o_redirect_pc=0x120, o_flush=1; IDLE after; br=1, taken=1.
- BNE, rs1=rs2=7 → no redirect, no flush; br_count increments, taken_count unchanged.
- JALR, rs1=0x1001, imm=0x0F, ready held 0 for 3 cycles → target 0x1010. valid, flush and stall stay high with the PC stable for 4 cycles; IDLE after ready=1. A second branch offered during the wait is not counted.
- JAL, pc=0x200, imm=0x6 → o_trap pulse of 1 cycle, o_trap_tval=0x206, o_redirect_valid=0, taken unchanged.
- BLTU, rs1=0x11111111, rs2=0x11111110 → not taken; BGEU with the same operands → redirect.
- i_rst asserted mid-REDIRECT → all outputs 0 immediately. With CNT_WIDTH=4 and 16 branches, o_br_count wraps to 0.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the execute-stage branch logic: operand width,
// BRANCH_* opcode encodings and the redirect controller state encoding.
package branch_redirect_ctrl_pkg;

    localparam int BR_DATA_WIDTH = 32;

    localparam logic [2:0] BRANCH_BEQ      = 3'd0;
    localparam logic [2:0] BRANCH_BNE      = 3'd1;
    localparam logic [2:0] BRANCH_JAL_JALR = 3'd2;
    localparam logic [2:0] BRANCH_BLT      = 3'd4;
    localparam logic [2:0] BRANCH_BGE      = 3'd5;
    localparam logic [2:0] BRANCH_BLTU     = 3'd6;
    localparam logic [2:0] BRANCH_BGEU     = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        TRAP     = 2'd2
    } redirect_state_e;

    // RV32I without compressed instructions needs 4-byte aligned targets.
    function automatic logic target_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_branch_unit.sv
// Branch comparator: decides whether the EX-stage branch/jump is taken.
// Output is forced low unless the enable (valid branch) is asserted.
module branch_unit
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = BR_DATA_WIDTH
) (
    input  logic                  i_en,
    input  logic [2:0]            i_branch_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_take
);

    logic cond_s;

    // Evaluate the branch condition for the requested opcode.
    always_comb begin
        cond_s = 1'b0;
        case (i_branch_op)
            BRANCH_BEQ:      cond_s = (i_a == i_b);
            BRANCH_BNE:      cond_s = (i_a != i_b);
            BRANCH_BLT:      cond_s = ($signed(i_a) <  $signed(i_b));
            BRANCH_BGE:      cond_s = ($signed(i_a) >= $signed(i_b));
            BRANCH_BLTU:     cond_s = (i_a <  i_b);
            BRANCH_BGEU:     cond_s = (i_a >= i_b);
            BRANCH_JAL_JALR: cond_s = 1'b1;
            default:         cond_s = 1'b0;
        endcase
    end

    assign o_take = i_en & cond_s;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch resolution: computes the target, issues a PC redirect
// (valid/ready) or a misaligned-target trap, and counts resolved/taken branches.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = BR_DATA_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ex_valid,
    input  logic                  i_branch,
    input  logic [2:0]            i_branch_op,
    input  logic                  i_jalr,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic                  i_redirect_ready,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic                  o_flush,
    output logic                  o_ex_stall,
    output logic                  o_trap,
    output logic [DATA_WIDTH-1:0] o_trap_tval,
    output logic [CNT_WIDTH-1:0]  o_br_count,
    output logic [CNT_WIDTH-1:0]  o_taken_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    redirect_state_e       state_r;
    redirect_state_e       state_next_s;
    logic                  take_s;
    logic                  event_s;
    logic                  redirect_load_s;
    logic                  trap_load_s;
    logic [DATA_WIDTH-1:0] sum_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic [DATA_WIDTH-1:0] redirect_pc_r;
    logic [DATA_WIDTH-1:0] trap_tval_r;
    logic [CNT_WIDTH-1:0]  br_cnt_r;
    logic [CNT_WIDTH-1:0]  taken_cnt_r;

    branch_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_branch_unit (
        .i_en        (i_branch & i_ex_valid),
        .i_branch_op (i_branch_op),
        .i_a         (i_rs1),
        .i_b         (i_rs2),
        .o_take      (take_s)
    );

    // JALR clears bit 0 of rs1+imm; other branches/JAL are PC-relative.
    assign sum_s    = (i_jalr ? i_rs1 : i_pc) + i_imm;
    assign target_s = i_jalr ? {sum_s[DATA_WIDTH-1:1], 1'b0} : sum_s;

    // Events only count in IDLE; anything offered while busy is ignored.
    assign event_s         = (state_r == IDLE) & i_ex_valid & i_branch;
    assign redirect_load_s = event_s & take_s & target_aligned(target_s[1:0]);
    assign trap_load_s     = event_s & take_s & ~target_aligned(target_s[1:0]);

    // Next-state selection for the redirect/trap sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (redirect_load_s) begin
                    state_next_s = REDIRECT;
                end else if (trap_load_s) begin
                    state_next_s = TRAP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REDIRECT: begin
                if (i_redirect_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REDIRECT;
                end
            end
            TRAP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; reset drops any pending redirect or trap at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Target capture: held stable for the whole redirect handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            redirect_pc_r <= '0;
            trap_tval_r   <= '0;
        end else begin
            if (redirect_load_s) begin
                redirect_pc_r <= target_s;
            end
            if (trap_load_s) begin
                trap_tval_r <= target_s;
            end
        end
    end

    // Performance counters, wrapping modulo 2^CNT_WIDTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_cnt_r    <= '0;
            taken_cnt_r <= '0;
        end else begin
            if (event_s) begin
                br_cnt_r <= br_cnt_r + CNT_ONE;
            end
            if (redirect_load_s) begin
                taken_cnt_r <= taken_cnt_r + CNT_ONE;
            end
        end
    end

    assign o_redirect_valid = (state_r == REDIRECT);
    assign o_ex_stall       = (state_r == REDIRECT);
    assign o_trap           = (state_r == TRAP);
    assign o_flush          = (state_r == REDIRECT) | (state_r == TRAP);
    assign o_redirect_pc    = redirect_pc_r;
    assign o_trap_tval      = trap_tval_r;
    assign o_br_count       = br_cnt_r;
    assign o_taken_count    = taken_cnt_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a behavioural model queues the
// expected redirect/trap per branch; a negedge monitor pops and compares.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        bit          is_trap;
        logic [31:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0, s_branch = 1'b0, s_jalr = 1'b0, s_ready = 1'b0;
    logic [2:0]    s_op = 3'd0;
    logic [DW-1:0] s_rs1 = '0, s_rs2 = '0, s_pc = '0, s_imm = '0;

    logic          redirect_valid, flush, ex_stall, trap;
    logic [DW-1:0] redirect_pc, trap_tval;
    logic [CW-1:0] br_count, taken_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    int          m_mode = 0;          // 0 free, 1 awaiting fetch, 2 trap cycle
    logic [CW-1:0] m_br = '0, m_taken = '0;
    bit          prev_valid_r = 1'b0;
    logic [DW-1:0] prev_pc_r = '0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(s_valid), .i_branch(s_branch),
        .i_branch_op(s_op), .i_jalr(s_jalr), .i_rs1(s_rs1), .i_rs2(s_rs2),
        .i_pc(s_pc), .i_imm(s_imm), .i_redirect_ready(s_ready),
        .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
        .o_flush(flush), .o_ex_stall(ex_stall), .o_trap(trap),
        .o_trap_tval(trap_tval), .o_br_count(br_count), .o_taken_count(taken_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_take(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            BRANCH_BEQ:      return a == b;
            BRANCH_BNE:      return a != b;
            BRANCH_BLT:      return sa < sb;
            BRANCH_BGE:      return sa >= sb;
            BRANCH_BLTU:     return a < b;
            BRANCH_BGEU:     return a >= b;
            BRANCH_JAL_JALR: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input bit jalr, input logic [31:0] rs1,
                                               input logic [31:0] pc, input logic [31:0] imm);
        logic [31:0] t;
        if (jalr) t = (rs1 + imm) & 32'hFFFF_FFFE;
        else      t = pc + imm;
        return t;
    endfunction

    // Reference model: decides each cycle's outcome from the offered inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= 0;
            m_br    <= '0;
            m_taken <= '0;
            exp_q.delete();
        end else if (m_mode == 1) begin
            if (s_ready) m_mode <= 0;
        end else if (m_mode == 2) begin
            m_mode <= 0;
        end else if (s_valid && s_branch) begin
            m_br <= m_br + 1'b1;
            if (ref_take(s_op, s_rs1, s_rs2)) begin
                if (ref_target(s_jalr, s_rs1, s_pc, s_imm) % 4 == 0) begin
                    exp_q.push_back('{is_trap: 1'b0, addr: ref_target(s_jalr, s_rs1, s_pc, s_imm)});
                    m_taken <= m_taken + 1'b1;
                    m_mode  <= 1;
                end else begin
                    exp_q.push_back('{is_trap: 1'b1, addr: ref_target(s_jalr, s_rs1, s_pc, s_imm)});
                    m_mode  <= 2;
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle against the model and the queue.
    always @(negedge clk) begin
        exp_t e;
        chk("br_count", {28'd0, br_count}, {28'd0, m_br});
        chk("taken_count", {28'd0, taken_count}, {28'd0, m_taken});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_mode == 1});
        chk("ex_stall", {31'd0, ex_stall}, {31'd0, m_mode == 1});
        chk("trap", {31'd0, trap}, {31'd0, m_mode == 2});
        chk("flush", {31'd0, flush}, {31'd0, m_mode != 0});
        if ((redirect_valid && !prev_valid_r) || trap) begin
            chk("queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("kind_is_trap", {31'd0, e.is_trap}, {31'd0, trap});
                chk(trap ? "trap_tval" : "redirect_pc", trap ? trap_tval : redirect_pc, e.addr);
            end
        end else if (redirect_valid) begin
            chk("redirect_pc_stable", redirect_pc, prev_pc_r);
        end
        prev_valid_r <= redirect_valid;
        prev_pc_r    <= redirect_pc;
    end

    task automatic drive(input bit v, input bit br, input logic [2:0] op, input bit jalr,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input bit rdy);
        s_valid = v; s_branch = br; s_op = op; s_jalr = jalr;
        s_rs1 = rs1; s_rs2 = rs2; s_pc = pc; s_imm = imm; s_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'b0, BRANCH_BEQ, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_pc"}, redirect_pc, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
        chk({tag, "_stall"}, {31'd0, ex_stall}, 32'd0);
        chk({tag, "_trap"}, {31'd0, trap}, 32'd0);
        chk({tag, "_tval"}, trap_tval, 32'd0);
        chk({tag, "_br"}, {28'd0, br_count}, 32'd0);
        chk({tag, "_taken"}, {28'd0, taken_count}, 32'd0);
    endtask

    logic [2:0] ops[7] = '{BRANCH_BEQ, BRANCH_BNE, BRANCH_JAL_JALR, BRANCH_BLT,
                           BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU};

    initial begin
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // BEQ taken, accepted immediately
        drive(1'b1, 1'b1, BRANCH_BEQ, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_valid", {31'd0, redirect_valid}, 32'd1);
        idle(1'b1);
        // BNE not taken
        drive(1'b1, 1'b1, BRANCH_BNE, 1'b0, 32'd7, 32'd7, 32'h104, 32'h40, 1'b1);
        chk("bne_valid", {31'd0, redirect_valid}, 32'd0);
        // JALR with fetch stalled three cycles; a branch offered meanwhile is ignored
        drive(1'b1, 1'b1, BRANCH_JAL_JALR, 1'b1, 32'h1001, 32'd0, 32'h108, 32'h0F, 1'b0);
        chk("jalr_pc", redirect_pc, 32'h1010);
        drive(1'b1, 1'b1, BRANCH_BEQ, 1'b0, 32'd1, 32'd1, 32'h10C, 32'h8, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("jalr_hold_valid", {31'd0, redirect_valid}, 32'd1);
        idle(1'b1);
        chk("jalr_done", {31'd0, redirect_valid}, 32'd0);
        chk("jalr_br", {28'd0, br_count}, 32'd3);
        // JAL to a misaligned target
        drive(1'b1, 1'b1, BRANCH_JAL_JALR, 1'b0, 32'd0, 32'd0, 32'h200, 32'h6, 1'b1);
        chk("jal_tval", trap_tval, 32'h206);
        chk("jal_trap", {31'd0, trap}, 32'd1);
        idle(1'b1);
        chk("jal_trap_end", {31'd0, trap}, 32'd0);
        chk("jal_taken", {28'd0, taken_count}, 32'd2);
        // unsigned compare pair
        drive(1'b1, 1'b1, BRANCH_BLTU, 1'b0, 32'h11111111, 32'h11111110, 32'h300, 32'h40, 1'b1);
        drive(1'b1, 1'b1, BRANCH_BGEU, 1'b0, 32'h11111111, 32'h11111110, 32'h300, 32'h40, 1'b1);
        chk("bgeu_pc", redirect_pc, 32'h340);
        idle(1'b1);
        // reset in the middle of a redirect
        drive(1'b1, 1'b1, BRANCH_BEQ, 1'b0, 32'd9, 32'd9, 32'h400, 32'h10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // sixteen not-taken branches wrap the 4-bit resolved counter
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b1, BRANCH_BNE, 1'b0, 32'd3, 32'd3, 32'h500, 32'h4, 1'b1);
        chk("br_wrap", {28'd0, br_count}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b, imm, pc;
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? a + $urandom_range(0, 2) - 1 : $urandom);
            pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
            imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : {$urandom_range(0, 63), 2'b00};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ops[$urandom_range(0, 6)],
                  $urandom_range(0, 1) == 1, a, b, pc, imm, $urandom_range(0, 1) == 1);
        end
        repeat (4) idle(1'b1);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
